// File: rtl/graph_pkg.sv
// Shared types for the CSR graph fetch path: address/vertex widths, the
// neighbour-fetch FSM state encoding and the read-tag carried down the return pipeline.
package graph_pkg;

   localparam int unsigned PROC_BITS_DEF = 4;

   typedef logic [31+PROC_BITS_DEF:0] addr_t;
   typedef logic [31:0]               vtx_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_START,
      RD_END,
      WAIT_IDX,
      STREAM,
      DRAIN
   } nf_state_e;

   // Per-cycle edge-read tag: which ports issued, and whether each word is the vertex's last.
   typedef struct packed {
      logic va;
      logic vb;
      logic la;
      logic lb;
   } rd_tag_t;

endpackage

// File: rtl/nbr_fifo.sv
// Neighbour output buffer: up to two writes (word 0 first, then word 1) and one read
// per cycle, with a free-slot count for the upstream credit check.
module nbr_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 33
) (
   input  logic                     clk_in,
   input  logic                     rst_in_n,
   input  logic [1:0]               wr_cnt,
   input  logic [WIDTH-1:0]         wr_data0,
   input  logic [WIDTH-1:0]         wr_data1,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   free_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;

   logic [WIDTH-1:0] mem_q [DEPTH];
   ptr_t wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
   ptr_t rd_ptr_q, rd_ptr_d;
   cnt_t count_q, count_d;
   logic pop;

   always_comb begin
      pop        = rd_en && (count_q != '0);
      wr_ptr_nxt = wr_ptr_q + ptr_t'(1);
      wr_ptr_d   = wr_ptr_q + ptr_t'(wr_cnt);
      rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
      count_d    = count_q + cnt_t'(wr_cnt) - cnt_t'(pop);
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (wr_cnt != 2'd0) mem_q[wr_ptr_q]   <= wr_data0;
      if (wr_cnt == 2'd2) mem_q[wr_ptr_nxt] <= wr_data1;
   end

   assign rd_data  = mem_q[rd_ptr_q];
   assign rd_valid = (count_q != '0);
   assign free_cnt = cnt_t'(DEPTH) - count_q;

endmodule

// File: rtl/neighbor_fetch.sv
// CSR neighbour fetcher: reads rowidx[v], rowidx[v+1], then streams edge[start..end-1].
// NEIGHBOR_FETCH_DUAL_PORT_EN enables the second edge read port (two reads per cycle).
module neighbor_fetch
   import graph_pkg::*;
#(
   parameter int unsigned PROC_BITS  = 4,
   parameter int unsigned PROC_ID    = 0,
   parameter int unsigned READ_LAT   = 2,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_in_n,
   input  logic [31:0]           vtx_in,
   input  logic                  vtx_valid_in,
   output logic                  vtx_ready_out,
   output logic [32+PROC_BITS-1:0] idx_addr,
   output logic                  idx_validin,
   input  logic [31:0]           rowidx_out,
   output logic [32+PROC_BITS-1:0] data_addra,
   output logic [32+PROC_BITS-1:0] data_addrb,
   output logic                  data_validina,
   output logic                  data_validinb,
   input  logic [31:0]           data_outa,
   input  logic [31:0]           data_outb,
   output logic [31:0]           nbr_out,
   output logic                  nbr_valid_out,
   input  logic                  nbr_ready_in,
   output logic                  nbr_last_out,
   output logic                  done_out,
   output logic [31:0]           degree_out,
   output logic                  err_out
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [PROC_BITS-1:0] TAG = PROC_BITS'(PROC_ID);
`ifdef NEIGHBOR_FETCH_DUAL_PORT_EN
   localparam int unsigned CREDIT = 2;
`else
   localparam int unsigned CREDIT = 1;
`endif

   typedef logic [CW-1:0] cnt_t;

   nf_state_e state_q, state_d;
   vtx_t      v_q, v_d, start_q, start_d, end_q, end_d;
   vtx_t      cur_q, cur_d, deg_q, deg_d;
   logic      ready_q, ready_d, done_q, done_d, err_q, err_d;
   cnt_t      infl_q, infl_d;
   logic [1:0] isr_q [READ_LAT];
   logic [1:0] isr_d [READ_LAT];
   rd_tag_t   esr_q [READ_LAT];
   rd_tag_t   esr_d [READ_LAT];
   rd_tag_t   issue, ret;

   logic [1:0]  wr_cnt;
   logic [32:0] fifo_rd;
   logic        fifo_valid, pop;
   cnt_t        free;

   assign ret    = esr_q[READ_LAT-1];
   assign wr_cnt = {1'b0, ret.va} + {1'b0, ret.vb};
   assign pop    = fifo_valid && nbr_ready_in;

   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      start_d = start_q;
      end_d   = end_q;
      cur_d   = cur_q;
      deg_d   = deg_q;
      err_d   = err_q;
      done_d  = 1'b0;
      issue   = '0;
      idx_validin = 1'b0;
      idx_addr    = '0;

      // isr tag: {valid, is_end}; the end word follows the start word by one cycle.
      isr_d[0] = {(state_q == RD_START) || (state_q == RD_END), state_q == RD_END};
      for (int unsigned i = 1; i < READ_LAT; i++) begin
         isr_d[i] = isr_q[i-1];
         esr_d[i] = esr_q[i-1];
      end
      if (isr_q[READ_LAT-1] == 2'b10) start_d = rowidx_out;

      case (state_q)
         IDLE: begin
            if (vtx_valid_in && ready_q) begin
               v_d     = vtx_in;
               state_d = RD_START;
            end
         end
         RD_START: begin
            idx_validin = 1'b1;
            idx_addr    = {TAG, v_q};
            state_d     = RD_END;
         end
         RD_END: begin
            idx_validin = 1'b1;
            idx_addr    = {TAG, v_q + 32'd1};
            state_d     = WAIT_IDX;
         end
         WAIT_IDX: begin
            if (isr_q[READ_LAT-1] == 2'b11) begin
               end_d = rowidx_out;
               if (rowidx_out > start_q) begin
                  cur_d   = start_q;
                  state_d = STREAM;
               end else begin
                  if (rowidx_out < start_q) err_d = 1'b1;
                  deg_d   = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         STREAM: begin
            // Credit covers words already in flight so the FIFO cannot overflow.
            if (32'(free) >= 32'(infl_q) + CREDIT) begin
               issue.va = 1'b1;
               issue.la = (cur_q + 32'd1 == end_q);
               cur_d    = cur_q + 32'd1;
`ifdef NEIGHBOR_FETCH_DUAL_PORT_EN
               if (cur_q + 32'd1 < end_q) begin
                  issue.vb = 1'b1;
                  issue.lb = (cur_q + 32'd2 == end_q);
                  cur_d    = cur_q + 32'd2;
               end
`endif
               if (cur_d == end_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && fifo_rd[32] && (infl_q == '0)) begin
               deg_d   = end_q - start_q;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      esr_d[0]      = issue;
      data_validina = issue.va;
      data_addra    = issue.va ? {TAG, cur_q} : '0;
      data_validinb = issue.vb;
      data_addrb    = issue.vb ? {TAG, cur_q + 32'd1} : '0;
      infl_d        = infl_q + cnt_t'({1'b0, issue.va} + {1'b0, issue.vb}) - cnt_t'(wr_cnt);
      ready_d       = (state_d == IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q <= IDLE;
         v_q     <= '0;
         start_q <= '0;
         end_q   <= '0;
         cur_q   <= '0;
         deg_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
         infl_q  <= '0;
         for (int unsigned i = 0; i < READ_LAT; i++) begin
            isr_q[i] <= '0;
            esr_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         start_q <= start_d;
         end_q   <= end_d;
         cur_q   <= cur_d;
         deg_q   <= deg_d;
         err_q   <= err_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         infl_q  <= infl_d;
         for (int unsigned i = 0; i < READ_LAT; i++) begin
            isr_q[i] <= isr_d[i];
            esr_q[i] <= esr_d[i];
         end
      end
   end

   nbr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (33)
   ) u_fifo (
      .clk_in   (clk_in),
      .rst_in_n (rst_in_n),
      .wr_cnt   (wr_cnt),
      .wr_data0 ({ret.la, data_outa}),
      .wr_data1 ({ret.lb, data_outb}),
      .rd_en    (nbr_ready_in),
      .rd_data  (fifo_rd),
      .rd_valid (fifo_valid),
      .free_cnt (free)
   );

   assign vtx_ready_out = ready_q;
   assign done_out      = done_q;
   assign degree_out    = deg_q;
   assign err_out       = err_q;
   assign nbr_valid_out = fifo_valid;
   assign nbr_out       = fifo_valid ? fifo_rd[31:0] : '0;
   assign nbr_last_out  = fifo_valid && fifo_rd[32];

endmodule

// File: tb/tb_neighbor_fetch.sv
// Directed bench for neighbor_fetch: table of CSR rows plus back-to-back and
// mid-stream reset sequences, against a fixed-latency memory model.
module tb_neighbor_fetch;

   localparam int unsigned PB    = 4;
   localparam int unsigned PID   = 5;
   localparam int unsigned RL    = 2;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = 32 + PB;
   localparam logic [PB-1:0] TAG = 4'd5;

   logic          clk_in = 1'b0;
   logic          rst_in_n;
   logic [31:0]   vtx_in;
   logic          vtx_valid_in;
   logic          vtx_ready_out;
   logic [AW-1:0] idx_addr, data_addra, data_addrb;
   logic          idx_validin, data_validina, data_validinb;
   logic [31:0]   rowidx_out, data_outa, data_outb;
   logic [31:0]   nbr_out, degree_out;
   logic          nbr_valid_out, nbr_ready_in, nbr_last_out, done_out, err_out;

   always #5 clk_in = ~clk_in;

   neighbor_fetch #(
      .PROC_BITS  (PB),
      .PROC_ID    (PID),
      .READ_LAT   (RL),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_in        (clk_in),
      .rst_in_n      (rst_in_n),
      .vtx_in        (vtx_in),
      .vtx_valid_in  (vtx_valid_in),
      .vtx_ready_out (vtx_ready_out),
      .idx_addr      (idx_addr),
      .idx_validin   (idx_validin),
      .rowidx_out    (rowidx_out),
      .data_addra    (data_addra),
      .data_addrb    (data_addrb),
      .data_validina (data_validina),
      .data_validinb (data_validinb),
      .data_outa     (data_outa),
      .data_outb     (data_outb),
      .nbr_out       (nbr_out),
      .nbr_valid_out (nbr_valid_out),
      .nbr_ready_in  (nbr_ready_in),
      .nbr_last_out  (nbr_last_out),
      .done_out      (done_out),
      .degree_out    (degree_out),
      .err_out       (err_out)
   );

   // Memory model: address captured each cycle, data presented READ_LAT cycles later.
   logic [31:0]   rowidx_mem [64];
   logic [AW-1:0] ip [RL];
   logic [AW-1:0] ap [RL];
   logic [AW-1:0] bp [RL];

   function automatic logic [31:0] edge_val(input logic [31:0] i);
      return (i * 32'h0001_0003) ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk_in) begin
      ip[0] <= idx_addr;
      ap[0] <= data_addra;
      bp[0] <= data_addrb;
      for (int i = 1; i < RL; i++) begin
         ip[i] <= ip[i-1];
         ap[i] <= ap[i-1];
         bp[i] <= bp[i-1];
      end
   end

   assign rowidx_out = (ip[RL-1][AW-1:32] == TAG) ? rowidx_mem[ip[RL-1][5:0]] : 32'hDEAD_BEEF;
   assign data_outa  = (ap[RL-1][AW-1:32] == TAG) ? edge_val(ap[RL-1][31:0]) : 32'hDEAD_BEEF;
   assign data_outb  = (bp[RL-1][AW-1:32] == TAG) ? edge_val(bp[RL-1][31:0]) : 32'hDEAD_BEEF;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Words issued but not yet consumed (FIFO occupancy plus in-flight reads).
   int issued = 0;
   int popped = 0;
   int max_occ = 0;
   always @(negedge clk_in) begin
      #2;
      if (!rst_in_n) begin
         issued = 0;
         popped = 0;
      end else begin
         issued = issued + int'(data_validina) + int'(data_validinb);
         popped = popped + int'(nbr_valid_out && nbr_ready_in);
         if (issued - popped > max_occ) max_occ = issued - popped;
      end
   end

   typedef struct {
      logic [31:0] v;
      logic [31:0] s;
      logic [31:0] e;
      int          exp_deg;
      int          stall_lo;
      int          stall_hi;
      logic        exp_err;
   } vec_t;

   vec_t tbl [6];

   task automatic chk_rst(input string p);
      chk({p, "_strobes"}, {idx_validin, data_validina, data_validinb}, 0);
      chk({p, "_flags"}, {vtx_ready_out, nbr_valid_out, nbr_last_out, done_out, err_out}, 0);
      chk({p, "_idx_addr"}, idx_addr, 0);
      chk({p, "_data_addr"}, {data_addra[31:0], data_addrb[31:0]}, 0);
      chk({p, "_nbr_out"}, nbr_out, 0);
      chk({p, "_degree"}, degree_out, 0);
   endtask

   task automatic send(input logic [31:0] v);
      @(negedge clk_in);
      vtx_in       = v;
      vtx_valid_in = 1'b1;
      for (int n = 0; n < 50 && !vtx_ready_out; n++) @(negedge clk_in);
      chk("accept_ready", vtx_ready_out, 1);
      @(posedge clk_in);
      #1 vtx_valid_in = 1'b0;
   endtask

   // Called just after the accept edge; cycle k=1 is the first cycle after accept.
   task automatic collect(input vec_t c);
      int got = 0, first_strobe = -1, first_valid = -1, last_hs = -1, done_cyc = -1;
      logic idx_ok = 1'b1, portb_bad = 1'b0, err_seen = 1'b0;
      logic [31:0] deg_seen = 32'hFFFF_FFFF;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk_in);
         nbr_ready_in = !(k >= c.stall_lo && k <= c.stall_hi);
         if (done_out) begin
            done_cyc = k;
            deg_seen = degree_out;
            err_seen = err_out;
            break;
         end
         if (k == 1) idx_ok &= idx_validin && (idx_addr == {TAG, c.v});
         if (k == 2) idx_ok &= idx_validin && (idx_addr == {TAG, c.v + 32'd1});
         if (k > 2 && idx_validin) idx_ok = 1'b0;
         if (data_validina && first_strobe < 0) first_strobe = k;
`ifndef NEIGHBOR_FETCH_DUAL_PORT_EN
         if (data_validinb || data_addrb != '0) portb_bad = 1'b1;
`endif
         if (nbr_valid_out) begin
            if (first_valid < 0) first_valid = k;
            if (nbr_ready_in) begin
               chk("nbr_data", nbr_out, edge_val(c.s + 32'(got)));
               chk("nbr_last", nbr_last_out, got == c.exp_deg - 1);
               got++;
               last_hs = k;
            end
         end
      end
      chk("done_seen", done_cyc > 0, 1);
      chk("nbr_count", got, c.exp_deg);
      chk("degree", deg_seen, c.exp_deg);
      chk("err", err_seen, c.exp_err);
      chk("idx_seq", idx_ok, 1);
`ifndef NEIGHBOR_FETCH_DUAL_PORT_EN
      chk("portb_idle", portb_bad, 0);
`endif
      if (c.exp_deg == 0) begin
         chk("done_lat_deg0", done_cyc, RL + 3);
      end else begin
         chk("done_after_last", done_cyc, last_hs + 1);
         chk("first_strobe", first_strobe, RL + 3);
         chk("first_valid", first_valid, 2 * RL + 4);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t c;
      tbl[0] = '{v: 32'd3,  s: 32'd10, e: 32'd15, exp_deg: 5,  stall_lo: 0, stall_hi: -1, exp_err: 1'b0};
      tbl[1] = '{v: 32'd6,  s: 32'd7,  e: 32'd7,  exp_deg: 0,  stall_lo: 0, stall_hi: -1, exp_err: 1'b0};
      tbl[2] = '{v: 32'd8,  s: 32'd9,  e: 32'd4,  exp_deg: 0,  stall_lo: 0, stall_hi: -1, exp_err: 1'b1};
      tbl[3] = '{v: 32'd10, s: 32'd20, e: 32'd21, exp_deg: 1,  stall_lo: 0, stall_hi: -1, exp_err: 1'b1};
      tbl[4] = '{v: 32'd12, s: 32'd30, e: 32'd32, exp_deg: 2,  stall_lo: 0, stall_hi: -1, exp_err: 1'b1};
      tbl[5] = '{v: 32'd14, s: 32'd40, e: 32'd60, exp_deg: 20, stall_lo: 5, stall_hi: 25, exp_err: 1'b1};
      for (int i = 0; i < 64; i++) rowidx_mem[i] = '0;
      foreach (tbl[i]) begin
         rowidx_mem[tbl[i].v[5:0]]         = tbl[i].s;
         rowidx_mem[tbl[i].v[5:0] + 6'd1]  = tbl[i].e;
      end
      rowidx_mem[16] = 32'd100;
      rowidx_mem[17] = 32'd103;

      rst_in_n     = 1'b0;
      vtx_in       = '0;
      vtx_valid_in = 1'b0;
      nbr_ready_in = 1'b1;
      repeat (2) @(negedge clk_in);
      chk_rst("reset");
      rst_in_n = 1'b1;

      foreach (tbl[i]) begin
         nbr_ready_in = 1'b1;
         send(tbl[i].v);
         collect(tbl[i]);
      end
      chk("max_occupancy", max_occ, DEPTH);

      // Back-to-back: second request held valid while the first streams.
      nbr_ready_in = 1'b1;
      @(negedge clk_in);
      vtx_in       = 32'd3;
      vtx_valid_in = 1'b1;
      chk("b2b_ready_a", vtx_ready_out, 1);
      @(posedge clk_in);
      #1 vtx_in = 32'd16;
      chk("b2b_busy", vtx_ready_out, 0);
      c = tbl[0];
      c.exp_err = 1'b1;
      collect(c);
      chk("b2b_ready_at_done", vtx_ready_out, 1);
      @(posedge clk_in);
      #1 vtx_valid_in = 1'b0;
      c = '{v: 32'd16, s: 32'd100, e: 32'd103, exp_deg: 3, stall_lo: 0, stall_hi: -1, exp_err: 1'b1};
      collect(c);

      // Reset in the middle of a degree-20 stream.
      nbr_ready_in = 1'b1;
      send(32'd14);
      repeat (10) @(negedge clk_in);
      #1 rst_in_n = 1'b0;
      #1 chk_rst("midrst");
      repeat (3) @(negedge clk_in);
      rst_in_n = 1'b1;
      send(32'd3);
      collect(tbl[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
